// File: rtl/cpu_pkg.sv
// Shared CPU definitions: run-controller state encoding, debug command codes
// and the HALT opcode shared with the instruction decoder.
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_STEP   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_HALTED = 3'd4,
      ST_FLUSH  = 3'd5
   } run_state_e;

   localparam logic [1:0] CMD_NOP   = 2'b00;
   localparam logic [1:0] CMD_RUN   = 2'b01;
   localparam logic [1:0] CMD_STEP  = 2'b10;
   localparam logic [1:0] CMD_CLEAR = 2'b11;

   localparam logic [5:0] OP_HALT = 6'b111111;

   function automatic logic is_enabled_state(run_state_e s);
      return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
   endfunction

endpackage

// File: rtl/pipeline_run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge i_clk) begin
      if (i_reset || clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipeline_run_controller.sv
// Debug-unit run controller: sequences pipeline enable/flush for run, single
// step, HALT drain and watchdog timeout.
//
// state  | meaning
// IDLE   | pipeline frozen, waiting for a command
// RUN    | free-running, watching for HALT in EX and the watchdog
// STEP   | one enabled cycle, then back to IDLE
// DRAIN  | HALT seen in EX; letting MEM/WB complete
// HALTED | program finished or timed out; only CLEAR leaves
// FLUSH  | one cycle clearing stage registers, PC and status
module pipeline_run_controller
   import cpu_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2,
   parameter int MAX_CYCLES   = 1024,
   parameter int CNT_W        = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [1:0]       i_cmd,
   input  logic             i_halt_in_ex,
   output logic             o_pipe_enable,
   output logic             o_pipe_flush,
   output logic             o_done,
   output logic             o_halted,
   output logic             o_timeout,
   output logic [2:0]       o_state,
   output logic [CNT_W-1:0] o_cycle_count
);

   localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
   localparam logic [CNT_W:0]     MAX_CMP    = (CNT_W+1)'(MAX_CYCLES);

   run_state_e         state, state_nxt;
   logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
   logic               done_nxt, halted_nxt, timeout_nxt;
   logic               cmd_accept;
   logic               timeout_hit;
   logic [CNT_W:0]     cnt_plus1;

   assign o_state       = state;
   assign o_pipe_enable = is_enabled_state(state);
   assign o_pipe_flush  = (state == ST_FLUSH);
   assign o_cmd_ready   = (state == ST_IDLE) || (state == ST_HALTED);
   assign cmd_accept    = i_cmd_valid && o_cmd_ready;

   // Compare one bit wider so MAX_CYCLES equal to 2**CNT_W is still reachable.
   assign cnt_plus1   = {1'b0, o_cycle_count} + (CNT_W+1)'(1);
   assign timeout_hit = (cnt_plus1 == MAX_CMP);

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .clear   (state == ST_FLUSH),
      .inc     (o_pipe_enable),
      .count   (o_cycle_count)
   );

   always_comb begin
      state_nxt   = state;
      drain_nxt   = drain_cnt;
      done_nxt    = 1'b0;
      halted_nxt  = o_halted;
      timeout_nxt = o_timeout;
      case (state)
         ST_IDLE: begin
            if (cmd_accept) begin
               case (i_cmd)
                  CMD_RUN:   state_nxt = ST_RUN;
                  CMD_STEP:  state_nxt = ST_STEP;
                  CMD_CLEAR: state_nxt = ST_FLUSH;
                  default:   state_nxt = ST_IDLE;
               endcase
            end
         end
         ST_RUN, ST_STEP: begin
            if (i_halt_in_ex) begin
               if (DRAIN_CYCLES == 0) begin
                  state_nxt  = ST_HALTED;
                  halted_nxt = 1'b1;
                  done_nxt   = 1'b1;
               end else begin
                  state_nxt = ST_DRAIN;
                  drain_nxt = DRAIN_LOAD;
               end
            end else if (state == ST_STEP) begin
               state_nxt = ST_IDLE;
               done_nxt  = 1'b1;
            end else if (timeout_hit) begin
               state_nxt   = ST_HALTED;
               halted_nxt  = 1'b1;
               timeout_nxt = 1'b1;
               done_nxt    = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (drain_cnt <= DRAIN_W'(1)) begin
               state_nxt  = ST_HALTED;
               drain_nxt  = '0;
               halted_nxt = 1'b1;
               done_nxt   = 1'b1;
            end else begin
               drain_nxt = drain_cnt - DRAIN_W'(1);
            end
         end
         ST_HALTED: begin
            if (cmd_accept && (i_cmd == CMD_CLEAR)) state_nxt = ST_FLUSH;
         end
         ST_FLUSH: begin
            state_nxt   = ST_IDLE;
            halted_nxt  = 1'b0;
            timeout_nxt = 1'b0;
            done_nxt    = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= ST_IDLE;
         drain_cnt <= '0;
         o_done    <= 1'b0;
         o_halted  <= 1'b0;
         o_timeout <= 1'b0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_nxt;
         o_done    <= done_nxt;
         o_halted  <= halted_nxt;
         o_timeout <= timeout_nxt;
      end
   end

endmodule
